lcd_ctrl: RTL and testbench



---
 rtl/lcd_pkg.sv | 47 ++++
 rtl/lcd_ctrl.sv | 143 ++++++++++++++
 tb/tb_lcd_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, init ROM and timing defaults for the character-LCD timing engine
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_INIT    = 3'd1,
        ST_IDLE    = 3'd2,
        ST_SETUP   = 3'd3,
        ST_PULSE   = 3'd4,
        ST_HOLD    = 3'd5,
        ST_EXEC    = 3'd6
    } lcd_state_t;

    // HD44780 bring-up: 8-bit/2-line, display on, clear, entry mode increment
    localparam logic [7:0] INIT_FUNC_SET = 8'h38;
    localparam logic [7:0] INIT_DISP_ON  = 8'h0C;
    localparam logic [7:0] INIT_CLEAR    = 8'h01;
    localparam logic [7:0] INIT_ENTRY    = 8'h06;
    localparam logic [1:0] INIT_LAST     = 2'd3;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    localparam int DEF_T_POWERUP = 750000;
    localparam int DEF_T_SETUP   = 2;
    localparam int DEF_T_EN      = 12;
    localparam int DEF_T_HOLD    = 2;
    localparam int DEF_T_CMD     = 2000;
    localparam int DEF_T_CLEAR   = 82000;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = INIT_FUNC_SET;
            2'd1:    b = INIT_DISP_ON;
            2'd2:    b = INIT_CLEAR;
            default: b = INIT_ENTRY;
        endcase
        return b;
    endfunction

    // Home ignores bit 0, so 0x03 is also a home command and needs the long wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
        return !rs && ((d == CMD_CLEAR) || (d == CMD_HOME) || (d == (CMD_HOME | 8'h01)));
    endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 timing engine: power-up wait, init sequence, per-byte setup/enable/hold/execute
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_POWERUP = DEF_T_POWERUP,
    parameter int T_SETUP   = DEF_T_SETUP,
    parameter int T_EN      = DEF_T_EN,
    parameter int T_HOLD    = DEF_T_HOLD,
    parameter int T_CMD     = DEF_T_CMD,
    parameter int T_CLEAR   = DEF_T_CLEAR
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_valid,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_init_done,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    localparam int T_MAX_A = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
    localparam int T_MAX_B = (T_CMD > T_EN) ? T_CMD : T_EN;
    localparam int T_MAX_C = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
    localparam int T_MAX_D = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int T_MAX   = (T_MAX_D > T_MAX_C) ? T_MAX_D : T_MAX_C;
    localparam int CW      = $clog2(T_MAX) + 1;

    localparam logic [CW-1:0] LD_POWERUP = CW'(T_POWERUP - 1);
    localparam logic [CW-1:0] LD_SETUP   = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_EN      = CW'(T_EN - 1);
    localparam logic [CW-1:0] LD_HOLD    = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_CMD     = CW'(T_CMD - 1);
    localparam logic [CW-1:0] LD_CLEAR   = CW'(T_CLEAR - 1);

    lcd_state_t    state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [1:0]    idx, idx_next;
    logic          rs_next;
    logic [7:0]    data_next;
    logic          done_next;
    logic          cnt_zero;

    assign cnt_zero = (cnt == '0);
    assign o_lcd_rw = 1'b0;

    always_comb begin
        state_next = state;
        cnt_next   = cnt_zero ? cnt : cnt - CW'(1);
        idx_next   = idx;
        rs_next    = o_lcd_rs;
        data_next  = o_lcd_data;
        done_next  = o_init_done;

        case (state)
            ST_POWERUP: begin
                if (cnt_zero) begin
                    state_next = ST_INIT;
                    idx_next   = 2'd0;
                end
            end
            ST_INIT: begin
                rs_next    = 1'b0;
                data_next  = init_rom(idx);
                state_next = ST_SETUP;
                cnt_next   = LD_SETUP;
            end
            ST_IDLE: begin
                if (i_valid && o_ready) begin
                    rs_next    = i_rs;
                    data_next  = i_data;
                    state_next = ST_SETUP;
                    cnt_next   = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_next = ST_PULSE;
                    cnt_next   = LD_EN;
                end
            end
            ST_PULSE: begin
                if (cnt_zero) begin
                    state_next = ST_HOLD;
                    cnt_next   = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_next = ST_EXEC;
                    cnt_next   = is_long_cmd(o_lcd_rs, o_lcd_data) ? LD_CLEAR : LD_CMD;
                end
            end
            ST_EXEC: begin
                if (cnt_zero) begin
                    if (o_init_done) begin
                        state_next = ST_IDLE;
                    end else if (idx == INIT_LAST) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        idx_next   = idx + 2'd1;
                        state_next = ST_INIT;
                    end
                end
            end
            default: begin
                state_next = ST_POWERUP;
                cnt_next   = LD_POWERUP;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_POWERUP;
            cnt         <= LD_POWERUP;
            idx         <= 2'd0;
            o_ready     <= 1'b0;
            o_init_done <= 1'b0;
            o_lcd_on    <= 1'b0;
            o_lcd_en    <= 1'b0;
            o_lcd_rs    <= 1'b0;
            o_lcd_data  <= 8'h00;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            o_ready     <= (state_next == ST_IDLE);
            o_init_done <= done_next;
            o_lcd_on    <= 1'b1;
            o_lcd_en    <= (state_next == ST_PULSE);
            o_lcd_rs    <= rs_next;
            o_lcd_data  <= data_next;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - self-checking bench for lcd_ctrl with small timing parameters
module tb_lcd_ctrl;

    localparam int TP = 10;
    localparam int TS = 2;
    localparam int TE = 3;
    localparam int TH = 2;
    localparam int TC = 5;
    localparam int TL = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_rs = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_ready, o_init_done, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
    logic [7:0] o_lcd_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         exp_exec;
        bit         noisy;
    } vec_t;

    vec_t       vecs[10];
    logic [7:0] rom[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    lcd_ctrl #(
        .T_POWERUP(TP), .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_CMD(TC), .T_CLEAR(TL)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .i_rs(i_rs), .i_data(i_data),
        .o_ready(o_ready), .o_init_done(o_init_done), .o_lcd_on(o_lcd_on),
        .o_lcd_en(o_lcd_en), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw), .o_lcd_data(o_lcd_data)
    );

    always #5 clk = ~clk;

    function automatic int exec_of(input logic rs, input logic [7:0] d);
        return (rs == 1'b0 && d >= 8'd1 && d <= 8'd3) ? TL : TC;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, o_ready, 0);
        chk({tag, "_init_done"}, o_init_done, 0);
        chk({tag, "_lcd_on"}, o_lcd_on, 0);
        chk({tag, "_lcd_en"}, o_lcd_en, 0);
        chk({tag, "_lcd_rs"}, o_lcd_rs, 0);
        chk({tag, "_lcd_rw"}, o_lcd_rw, 0);
        chk({tag, "_lcd_data"}, o_lcd_data, 0);
    endtask

    // Releases reset and follows power-up plus init, comparing pulse timing against the arithmetic schedule
    task automatic run_init(input string tag, input bit noisy);
        int         rises[$];
        int         widths[$];
        logic [7:0] datas[$];
        logic       rss[$];
        int         n = 0;
        int         ready_at = -1;
        int         exp_rise;
        bit         early_done = 0;
        bit         prev_en = 0;
        @(negedge clk);
        rst = 1'b0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) chk({tag, "_lcd_on"}, o_lcd_on, 1);
            if (o_lcd_en && !prev_en) begin
                rises.push_back(n);
                widths.push_back(0);
                datas.push_back(o_lcd_data);
                rss.push_back(o_lcd_rs);
            end
            if (o_lcd_en) widths[widths.size()-1] = widths[widths.size()-1] + 1;
            prev_en = o_lcd_en;
            if (o_ready) begin
                ready_at = n;
                break;
            end
            if (o_init_done) early_done = 1;
            if (noisy) begin
                i_valid = 1'b1;
                i_rs    = 1'($urandom);
                i_data  = 8'($urandom);
            end
        end
        i_valid = 1'b0;
        chk({tag, "_pulse_count"}, rises.size(), 4);
        exp_rise = TP + 1 + TS;
        for (int k = 0; k < 4; k++) begin
            if (k < rises.size()) begin
                chk($sformatf("%s_rise%0d", tag, k), rises[k], exp_rise);
                chk($sformatf("%s_width%0d", tag, k), widths[k], TE);
                chk($sformatf("%s_data%0d", tag, k), datas[k], rom[k]);
                chk($sformatf("%s_rs%0d", tag, k), rss[k], 0);
            end
            exp_rise += 1 + TS + TE + TH + exec_of(1'b0, rom[k]);
        end
        chk({tag, "_ready_at"}, ready_at, exp_rise - 1 - TS);
        chk({tag, "_done_at_ready"}, o_init_done, 1);
        chk({tag, "_done_early"}, early_done, 0);
    endtask

    task automatic wait_ready(input string tag);
        int w = 0;
        while (!o_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_ready_wait"}, o_ready, 1);
    endtask

    // One byte: accept at the current negedge, then measure EN and the ready return relative to it
    task automatic xfer(input string tag, input logic rs, input logic [7:0] d,
                        input int exp_x, input bit noisy);
        int         n = 0;
        int         rise = -1;
        int         width = 0;
        int         back = -1;
        logic       got_rs = 1'b0;
        logic [7:0] got_d = 8'h00;
        wait_ready(tag);
        i_valid = 1'b1;
        i_rs    = rs;
        i_data  = d;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (n == 1) chk({tag, "_ready_drop"}, o_ready, 0);
            if (o_lcd_en) begin
                if (rise < 0) begin
                    rise   = n;
                    got_rs = o_lcd_rs;
                    got_d  = o_lcd_data;
                end
                width++;
            end
            if (o_ready) begin
                back = n;
                break;
            end
            if (noisy) begin
                i_valid = 1'b1;
                i_rs    = 1'($urandom);
                i_data  = d ^ 8'($urandom_range(1, 255));
            end else begin
                i_valid = 1'b0;
            end
        end
        chk({tag, "_en_rise"}, rise, 1 + TS);
        chk({tag, "_en_width"}, width, TE);
        chk({tag, "_rs"}, got_rs, rs);
        chk({tag, "_data"}, got_d, d);
        chk({tag, "_ready_back"}, back, 1 + TS + TE + TH + exp_x);
        chk({tag, "_data_idle"}, o_lcd_data, d);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int t;
        logic       rrs;
        logic [7:0] rd;

        vecs[0] = '{rs: 1'b1, data: 8'h41, exp_exec: TC, noisy: 1'b0};
        vecs[1] = '{rs: 1'b0, data: 8'h01, exp_exec: TL, noisy: 1'b0};
        vecs[2] = '{rs: 1'b1, data: 8'h01, exp_exec: TC, noisy: 1'b0};
        vecs[3] = '{rs: 1'b0, data: 8'h02, exp_exec: TL, noisy: 1'b0};
        vecs[4] = '{rs: 1'b0, data: 8'h03, exp_exec: TL, noisy: 1'b0};
        vecs[5] = '{rs: 1'b0, data: 8'h04, exp_exec: TC, noisy: 1'b0};
        vecs[6] = '{rs: 1'b1, data: 8'h30, exp_exec: TC, noisy: 1'b1};
        vecs[7] = '{rs: 1'b1, data: 8'h31, exp_exec: TC, noisy: 1'b1};
        vecs[8] = '{rs: 1'b0, data: 8'h01, exp_exec: TL, noisy: 1'b1};
        vecs[9] = '{rs: 1'b1, data: 8'h32, exp_exec: TC, noisy: 1'b1};

        repeat (3) @(negedge clk);
        chk_reset_vals("rst0");
        run_init("init0", 1'b0);

        for (int i = 0; i < 10; i++)
            xfer($sformatf("vec%0d", i), vecs[i].rs, vecs[i].data, vecs[i].exp_exec, vecs[i].noisy);
        i_valid = 1'b0;

        for (int i = 0; i < 12; i++) begin
            rrs = 1'($urandom_range(0, 1));
            rd  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            xfer($sformatf("rnd%0d", i), rrs, rd, exec_of(rrs, rd), 1'($urandom_range(0, 1)));
        end
        i_valid = 1'b0;

        // Reset asserted between clock edges while EN is high must clear outputs without a clock
        wait_ready("mid");
        i_valid = 1'b1;
        i_rs    = 1'b1;
        i_data  = 8'h55;
        @(negedge clk);
        i_valid = 1'b0;
        t = 0;
        while (!o_lcd_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("mid_en_seen", o_lcd_en, 1);
        #2 rst = 1'b1;
        #1 chk_reset_vals("async");
        repeat (2) @(negedge clk);
        chk_reset_vals("held");
        run_init("init1", 1'b1);
        xfer("post", 1'b1, 8'h5A, TC, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
